// File: rtl/biphasic_wavegen_mc.sv
// biphasic_wavegen_mc: multi-channel charge-balanced biphasic pulse
// sequencer with repeat count, inter-pulse gap and safe stop.
module biphasic_wavegen_mc #(
  parameter int NCH = 4,
  parameter int TW  = 12,
  parameter int AW  = 6,
  parameter int RW  = 8,
  parameter int CW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_f,
  input  logic              stop_f,
  input  logic [CW-1:0]     chan,
  input  logic              polarity,
  input  logic [TW-1:0]     ktp,
  input  logic [AW-1:0]     sktp,
  input  logic [TW-1:0]     ipd,
  input  logic [TW-1:0]     adp,
  input  logic [AW-1:0]     sadp,
  input  logic [TW-1:0]     ipp,
  input  logic [RW-1:0]     nrep,
  output logic              busy,
  output logic              done_f,
  output logic [NCH*AW-1:0] sink,
  output logic [NCH*AW-1:0] src
);

  typedef enum logic [2:0] {
    IDLE, PH1, IPD, PH2, GAP, DONE
  } state_t;

  localparam logic [TW-1:0] T1 = TW'(1);
  localparam logic [RW-1:0] R1 = RW'(1);

  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [RW-1:0] rep, rep_n;
  logic stop_pend, stop_n;

  logic [CW-1:0] ch_q;
  logic          pol_q;
  logic [TW-1:0] ktp_q, ipd_q, adp_q, ipp_q;
  logic [AW-1:0] sktp_q, sadp_q;
  logic          cont_q;

  logic          idle;
  logic [CW-1:0] c_ch;
  logic          c_pol;
  logic [TW-1:0] c_ktp, c_ipd, c_adp, c_ipp;
  logic [AW-1:0] c_sktp, c_sadp;
  logic [TW-1:0] d1, d2;

  state_t st_a, st_b, st_c;
  logic [TW-1:0] cn_a, cn_b, cn_c;
  logic stop_eff, last, pulse_end;
  logic drv_sink, drv_src;
  logic [NCH*AW-1:0] sink_n, src_n;

  // In IDLE the live inputs are used: they are latched on the start edge
  assign idle   = (state == IDLE);
  assign c_ch   = idle ? chan     : ch_q;
  assign c_pol  = idle ? polarity : pol_q;
  assign c_ktp  = idle ? ktp      : ktp_q;
  assign c_ipd  = idle ? ipd      : ipd_q;
  assign c_adp  = idle ? adp      : adp_q;
  assign c_ipp  = idle ? ipp      : ipp_q;
  assign c_sktp = idle ? sktp     : sktp_q;
  assign c_sadp = idle ? sadp     : sadp_q;

  assign d1 = c_pol ? c_adp : c_ktp;
  assign d2 = c_pol ? c_ktp : c_adp;

  // First non-empty phase from PH1/IPD/PH2 on; DONE marks pulse end
  always_comb begin
    st_c = (d2 != '0) ? PH2 : DONE;
    cn_c = d2 - T1;
    st_b = st_c;
    cn_b = cn_c;
    if (c_ipd != '0) begin
      st_b = IPD;
      cn_b = c_ipd - T1;
    end
    st_a = st_b;
    cn_a = cn_b;
    if (d1 != '0) begin
      st_a = PH1;
      cn_a = d1 - T1;
    end
  end

  assign stop_eff = stop_pend | stop_f;
  assign last     = !cont_q && (rep == R1);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt - T1;
    rep_n     = rep;
    stop_n    = stop_eff;
    pulse_end = 1'b0;
    unique case (state)
      IDLE: begin
        stop_n = start_f & stop_f;
        if (start_f) begin
          state_n = st_a;
          cnt_n   = cn_a;
          rep_n   = nrep;
        end
      end
      PH1: if (cnt == '0) begin
        state_n   = st_b;
        cnt_n     = cn_b;
        pulse_end = (st_b == DONE);
      end
      IPD: if (cnt == '0) begin
        state_n   = st_c;
        cnt_n     = cn_c;
        pulse_end = (st_c == DONE);
      end
      PH2: if (cnt == '0) pulse_end = 1'b1;
      GAP: begin
        if (stop_eff) begin
          state_n = DONE;
        end else if (cnt == '0) begin
          state_n = st_a;
          cnt_n   = cn_a;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (pulse_end) begin
      if (!cont_q) rep_n = rep - R1;
      if (last || stop_eff) begin
        state_n = DONE;
      end else if (c_ipp != '0) begin
        state_n = GAP;
        cnt_n   = c_ipp - T1;
      end else begin
        state_n = st_a;
        cnt_n   = cn_a;
      end
    end
    if (state_n == IDLE || state_n == DONE)
      cnt_n = '0;
  end

  assign drv_sink = (state_n == PH1 && !c_pol) ||
                    (state_n == PH2 &&  c_pol);
  assign drv_src  = (state_n == PH1 &&  c_pol) ||
                    (state_n == PH2 && !c_pol);

  always_comb begin
    sink_n = '0;
    src_n  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (c_ch == CW'(k)) begin
        if (drv_sink) sink_n[k*AW +: AW] = c_sktp;
        if (drv_src)  src_n[k*AW +: AW]  = c_sadp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rep       <= '0;
      stop_pend <= 1'b0;
      busy      <= 1'b0;
      done_f    <= 1'b0;
      sink      <= '0;
      src       <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rep       <= rep_n;
      stop_pend <= stop_n;
      busy      <= (state_n != IDLE);
      done_f    <= (state_n == DONE);
      sink      <= sink_n;
      src       <= src_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_q   <= '0;
      pol_q  <= 1'b0;
      ktp_q  <= '0;
      ipd_q  <= '0;
      adp_q  <= '0;
      ipp_q  <= '0;
      sktp_q <= '0;
      sadp_q <= '0;
      cont_q <= 1'b0;
    end else if (idle && start_f) begin
      ch_q   <= chan;
      pol_q  <= polarity;
      ktp_q  <= ktp;
      ipd_q  <= ipd;
      adp_q  <= adp;
      ipp_q  <= ipp;
      sktp_q <= sktp;
      sadp_q <= sadp;
      cont_q <= (nrep == '0);
    end
  end

endmodule
